// File: rtl/mshr_line_buffer_if.sv
// Bundle of refill-write, clear, read-request and read-response signals
// exchanged between the miss-handling logic and the MSHR line buffer.
interface mshr_line_buffer_if #(
    parameter int N_ENTRY = 4,
    parameter int BEATS   = 4,
    parameter int DATA_W  = 64,
    parameter int N_SRC   = 4
);
    localparam int ID_W   = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic              io_write_valid;
    logic [ID_W-1:0]   io_write_id;
    logic [BEAT_W-1:0] io_write_beat;
    logic [DATA_W-1:0] io_write_data;

    logic              io_clear_valid;
    logic [ID_W-1:0]   io_clear_id;

    logic              io_req_valid;
    logic              io_req_ready;
    logic [ID_W-1:0]   io_req_id;
    logic [BEAT_W-1:0] io_req_beat;
    logic [SRC_W-1:0]  io_req_src;

    logic              io_resp_valid;
    logic              io_resp_ready;
    logic [DATA_W-1:0] io_resp_data;
    logic [SRC_W-1:0]  io_resp_src;

    modport master (
        output io_write_valid, io_write_id, io_write_beat, io_write_data,
        output io_clear_valid, io_clear_id,
        output io_req_valid, io_req_id, io_req_beat, io_req_src,
        output io_resp_ready,
        input  io_req_ready, io_resp_valid, io_resp_data, io_resp_src
    );

    modport slave (
        input  io_write_valid, io_write_id, io_write_beat, io_write_data,
        input  io_clear_valid, io_clear_id,
        input  io_req_valid, io_req_id, io_req_beat, io_req_src,
        input  io_resp_ready,
        output io_req_ready, io_resp_valid, io_resp_data, io_resp_src
    );
endinterface

// File: rtl/mshr_line_buffer.sv
// Per-MSHR refill line buffer: beat-granular valid tracking, write bypass on
// reads and a single registered response stage with valid/ready handshake.
module mshr_line_buffer #(
    parameter int N_ENTRY = 4,
    parameter int BEATS   = 4,
    parameter int DATA_W  = 64,
    parameter int N_SRC   = 4
) (
    input  logic             clock,
    input  logic             reset,
    mshr_line_buffer_if.slave bus
);
    localparam int ID_W   = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [DATA_W-1:0] mem_r       [N_ENTRY][BEATS];
    logic [BEATS-1:0]  valid_r     [N_ENTRY];
    logic [BEATS-1:0]  valid_nxt_s [N_ENTRY];

    logic              bypass_s;
    logic              avail_s;
    logic              ready_s;
    logic              accept_s;
    logic [DATA_W-1:0] rd_data_s;

    logic              resp_valid_r;
    logic [DATA_W-1:0] resp_data_r;
    logic [SRC_W-1:0]  resp_src_r;

    // Availability and read data; a same-cycle write wins over stored state.
    always_comb begin
        bypass_s = bus.io_write_valid
                   && (bus.io_write_id == bus.io_req_id)
                   && (bus.io_write_beat == bus.io_req_beat);
        avail_s  = valid_r[bus.io_req_id][bus.io_req_beat] | bypass_s;
        ready_s  = avail_s && (!resp_valid_r || bus.io_resp_ready);
        accept_s = bus.io_req_valid && ready_s;
        if (bypass_s) begin
            rd_data_s = bus.io_write_data;
        end else begin
            rd_data_s = mem_r[bus.io_req_id][bus.io_req_beat];
        end
    end

    // Next beat-valid state: clear first, then the write sets its beat.
    always_comb begin
        for (int e = 0; e < N_ENTRY; e++) begin
            for (int b = 0; b < BEATS; b++) begin
                valid_nxt_s[e][b] = valid_r[e][b];
                if (bus.io_clear_valid && (bus.io_clear_id == ID_W'(e))) begin
                    valid_nxt_s[e][b] = 1'b0;
                end else begin
                    valid_nxt_s[e][b] = valid_r[e][b];
                end
                if (bus.io_write_valid && (bus.io_write_id == ID_W'(e))
                    && (bus.io_write_beat == BEAT_W'(b))) begin
                    valid_nxt_s[e][b] = 1'b1;
                end else begin
                    valid_nxt_s[e][b] = valid_nxt_s[e][b];
                end
            end
        end
    end

    // Beat-valid register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < N_ENTRY; e++) begin
                valid_r[e] <= '0;
            end
        end else begin
            for (int e = 0; e < N_ENTRY; e++) begin
                valid_r[e] <= valid_nxt_s[e];
            end
        end
    end

    // Data storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (bus.io_write_valid) begin
            mem_r[bus.io_write_id][bus.io_write_beat] <= bus.io_write_data;
        end
    end

    // Response stage: load on accept, drop on fire, otherwise hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_valid_r <= 1'b0;
            resp_data_r  <= '0;
            resp_src_r   <= '0;
        end else if (accept_s) begin
            resp_valid_r <= 1'b1;
            resp_data_r  <= rd_data_s;
            resp_src_r   <= bus.io_req_src;
        end else if (bus.io_resp_ready) begin
            resp_valid_r <= 1'b0;
        end else begin
            resp_valid_r <= resp_valid_r;
        end
    end

    assign bus.io_req_ready  = ready_s;
    assign bus.io_resp_valid = resp_valid_r;
    assign bus.io_resp_data  = resp_data_r;
    assign bus.io_resp_src   = resp_src_r;
endmodule

// File: tb/tb_mshr_line_buffer.sv
// Directed, table-driven bench for mshr_line_buffer with hand-written
// reset sequences around the vector table.
module tb_mshr_line_buffer;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    mshr_line_buffer_if bus ();

    mshr_line_buffer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        wv;
        logic [1:0]  wid;
        logic [1:0]  wbeat;
        logic [63:0] wdata;
        logic        cv;
        logic [1:0]  cid;
        logic        rv;
        logic [1:0]  rid;
        logic [1:0]  rbeat;
        logic [1:0]  rsrc;
        logic        rr;
        logic        exp_ready;
        logic        exp_rv;
        logic        chk_d;
        logic [63:0] exp_data;
        logic [1:0]  exp_src;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic wv, input logic [1:0] wid, input logic [1:0] wbeat,
        input logic [63:0] wdata, input logic cv, input logic [1:0] cid,
        input logic rv, input logic [1:0] rid, input logic [1:0] rbeat,
        input logic [1:0] rsrc, input logic rr, input logic exp_ready,
        input logic exp_rv, input logic chk_d, input logic [63:0] exp_data,
        input logic [1:0] exp_src);
        vec_t v;
        v.wv = wv; v.wid = wid; v.wbeat = wbeat; v.wdata = wdata;
        v.cv = cv; v.cid = cid; v.rv = rv; v.rid = rid; v.rbeat = rbeat;
        v.rsrc = rsrc; v.rr = rr; v.exp_ready = exp_ready; v.exp_rv = exp_rv;
        v.chk_d = chk_d; v.exp_data = exp_data; v.exp_src = exp_src;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.io_write_valid = v.wv;
        bus.io_write_id    = v.wid;
        bus.io_write_beat  = v.wbeat;
        bus.io_write_data  = v.wdata;
        bus.io_clear_valid = v.cv;
        bus.io_clear_id    = v.cid;
        bus.io_req_valid   = v.rv;
        bus.io_req_id      = v.rid;
        bus.io_req_beat    = v.rbeat;
        bus.io_req_src     = v.rsrc;
        bus.io_resp_ready  = v.rr;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // after reset: write e1 b2, then read it
        tbl.push_back(mk(1'b1,2'd1,2'd2,64'hA5A5, 1'b0,2'd0, 1'b0,2'd0,2'd0,2'd0, 1'b1, 1'b0,1'b0,1'b0,64'h0,2'd0));
        tbl.push_back(mk(1'b0,2'd0,2'd0,64'h0,    1'b0,2'd0, 1'b1,2'd1,2'd2,2'd3, 1'b1, 1'b1,1'b1,1'b1,64'hA5A5,2'd3));
        tbl.push_back(mk(1'b0,2'd0,2'd0,64'h0,    1'b0,2'd0, 1'b0,2'd0,2'd0,2'd0, 1'b1, 1'b0,1'b0,1'b0,64'h0,2'd0));
        // stall on unwritten e0 b0 for three cycles, then bypass write
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0,2'd0,2'd0,64'h0, 1'b0,2'd0, 1'b1,2'd0,2'd0,2'd1, 1'b1, 1'b0,1'b0,1'b0,64'h0,2'd0));
        tbl.push_back(mk(1'b1,2'd0,2'd0,64'h1234, 1'b0,2'd0, 1'b1,2'd0,2'd0,2'd1, 1'b1, 1'b1,1'b1,1'b1,64'h1234,2'd1));
        // backpressure two cycles, then back-to-back
        for (int i = 0; i < 2; i++)
            tbl.push_back(mk(1'b0,2'd0,2'd0,64'h0, 1'b0,2'd0, 1'b1,2'd1,2'd2,2'd2, 1'b0, 1'b0,1'b1,1'b1,64'h1234,2'd1));
        tbl.push_back(mk(1'b0,2'd0,2'd0,64'h0,    1'b0,2'd0, 1'b1,2'd1,2'd2,2'd2, 1'b1, 1'b1,1'b1,1'b1,64'hA5A5,2'd2));
        tbl.push_back(mk(1'b0,2'd0,2'd0,64'h0,    1'b0,2'd0, 1'b1,2'd0,2'd0,2'd0, 1'b1, 1'b1,1'b1,1'b1,64'h1234,2'd0));
        // ready does not depend on req_valid
        tbl.push_back(mk(1'b0,2'd0,2'd0,64'h0,    1'b0,2'd0, 1'b0,2'd0,2'd0,2'd0, 1'b1, 1'b1,1'b0,1'b0,64'h0,2'd0));
        // clear e2 while writing e2 b1; stored state governs same-cycle read
        tbl.push_back(mk(1'b1,2'd2,2'd0,64'h77,   1'b0,2'd0, 1'b0,2'd3,2'd0,2'd0, 1'b1, 1'b0,1'b0,1'b0,64'h0,2'd0));
        tbl.push_back(mk(1'b1,2'd2,2'd1,64'h55,   1'b1,2'd2, 1'b1,2'd2,2'd0,2'd0, 1'b1, 1'b1,1'b1,1'b1,64'h77,2'd0));
        tbl.push_back(mk(1'b0,2'd0,2'd0,64'h0,    1'b0,2'd0, 1'b1,2'd2,2'd0,2'd0, 1'b1, 1'b0,1'b0,1'b0,64'h0,2'd0));
        tbl.push_back(mk(1'b0,2'd0,2'd0,64'h0,    1'b0,2'd0, 1'b1,2'd2,2'd1,2'd1, 1'b1, 1'b1,1'b1,1'b1,64'h55,2'd1));
        tbl.push_back(mk(1'b0,2'd0,2'd0,64'h0,    1'b0,2'd0, 1'b0,2'd3,2'd0,2'd0, 1'b1, 1'b0,1'b0,1'b0,64'h0,2'd0));
        // fill entry 3; last write bypasses the idle request fields
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b1,2'd3,2'(i),64'h3000 + 64'(i), 1'b0,2'd0, 1'b0,2'd3,2'd3,2'd0, 1'b1,
                             (i == 3) ? 1'b1 : 1'b0, 1'b0,1'b0,64'h0,2'd0));
        // stream all beats of entry 3
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b0,2'd0,2'd0,64'h0, 1'b0,2'd0, 1'b1,2'd3,2'(i),2'(3 - i), 1'b1,
                             1'b1,1'b1,1'b1,64'h3000 + 64'(i),2'(3 - i)));
        tbl.push_back(mk(1'b0,2'd0,2'd0,64'h0,    1'b0,2'd0, 1'b0,2'd2,2'd2,2'd0, 1'b1, 1'b0,1'b0,1'b0,64'h0,2'd0));

        // power-on reset
        reset = 1'b0;
        drive(mk(1'b0,2'd0,2'd0,64'h0, 1'b0,2'd0, 1'b0,2'd0,2'd0,2'd0, 1'b1, 1'b0,1'b0,1'b0,64'h0,2'd0));
        repeat (2) @(posedge clock);
        #1;
        chk("reset_resp_valid", 64'(bus.io_resp_valid), 64'h0);
        chk("reset_resp_data",  bus.io_resp_data, 64'h0);
        chk("reset_resp_src",   64'(bus.io_resp_src), 64'h0);
        chk("reset_req_ready",  64'(bus.io_req_ready), 64'h0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d_req_ready", i), 64'(bus.io_req_ready), 64'(tbl[i].exp_ready));
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_resp_valid", i), 64'(bus.io_resp_valid), 64'(tbl[i].exp_rv));
            if (tbl[i].chk_d) begin
                chk($sformatf("v%0d_resp_data", i), bus.io_resp_data, tbl[i].exp_data);
                chk($sformatf("v%0d_resp_src", i), 64'(bus.io_resp_src), 64'(tbl[i].exp_src));
            end
        end

        // reset while a response is pending
        @(negedge clock);
        drive(mk(1'b0,2'd0,2'd0,64'h0, 1'b0,2'd0, 1'b1,2'd3,2'd0,2'd2, 1'b0, 1'b0,1'b0,1'b0,64'h0,2'd0));
        #1;
        chk("mid_req_ready", 64'(bus.io_req_ready), 64'h1);
        @(posedge clock);
        #1;
        bus.io_req_valid = 1'b0;
        chk("mid_resp_valid", 64'(bus.io_resp_valid), 64'h1);
        chk("mid_resp_data",  bus.io_resp_data, 64'h3000);
        #2;
        reset = 1'b0;
        #1;
        chk("async_resp_valid", 64'(bus.io_resp_valid), 64'h0);
        chk("async_resp_data",  bus.io_resp_data, 64'h0);
        chk("async_resp_src",   64'(bus.io_resp_src), 64'h0);
        chk("async_req_ready",  64'(bus.io_req_ready), 64'h0);
        bus.io_write_valid = 1'b1;
        bus.io_write_id    = 2'd1;
        bus.io_write_beat  = 2'd1;
        bus.io_write_data  = 64'h99;
        bus.io_req_id      = 2'd1;
        bus.io_req_beat    = 2'd1;
        #1;
        chk("reset_bypass_ready", 64'(bus.io_req_ready), 64'h1);
        bus.io_write_valid = 1'b0;
        #1;
        chk("reset_nobypass_ready", 64'(bus.io_req_ready), 64'h0);
        @(negedge clock);
        reset = 1'b1;
        bus.io_resp_ready = 1'b1;
        bus.io_req_id     = 2'd3;
        bus.io_req_beat   = 2'd0;
        @(posedge clock);
        #1;
        chk("post_reset_e3b0_ready", 64'(bus.io_req_ready), 64'h0);
        chk("post_reset_resp_valid", 64'(bus.io_resp_valid), 64'h0);
        bus.io_req_id   = 2'd1;
        bus.io_req_beat = 2'd2;
        #1;
        chk("post_reset_e1b2_ready", 64'(bus.io_req_ready), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
